// File: rtl/sar_search.sv
// Successive-approximation search initiator: issues candidate guesses to an external
// comparator and binary-searches to its hidden target. Optional SAR_ITER_COUNT_EN adds iter_count.
module sar_search #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    input  logic             resp_valid,
    input  logic             resp_gt,
    input  logic             resp_lt,
    input  logic             resp_eq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] found,
    output logic             err
`ifdef SAR_ITER_COUNT_EN
    ,
    output logic [7:0]       iter_count
`endif
);

    localparam int unsigned WP1 = WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEXT,
        S_QUERY,
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WP1-1:0]   r_lo, r_hi, w_lo_nxt, w_hi_nxt;
    logic [WP1-1:0]   w_mid, w_guess_ext;
    logic [WIDTH-1:0] r_guess, r_found, w_guess_nxt, w_found_nxt;
    logic             r_guess_valid, r_busy, r_done, r_err;
    logic             w_start_acc, w_accept, w_onehot;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_accept    = (r_state == S_QUERY) && resp_valid;
    assign w_onehot    = $onehot({resp_gt, resp_lt, resp_eq});
    assign w_mid       = r_lo + ((r_hi - r_lo) >> 1);
    assign w_guess_ext = {1'b0, r_guess};

    // Next-state and datapath update; range-exhaustion checks keep lo/hi from wrapping
    always_comb begin
        w_state_nxt = r_state;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_guess_nxt = r_guess;
        w_found_nxt = r_found;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_lo_nxt    = '0;
                    w_hi_nxt    = WP1'((32'd1 << WIDTH) - 32'd1);
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_guess_nxt = WIDTH'(w_mid);
                w_state_nxt = S_QUERY;
            end
            S_QUERY: begin
                if (w_accept) begin
                    if (!w_onehot) begin
                        w_state_nxt = S_ERR;
                    end else if (resp_eq) begin
                        w_found_nxt = r_guess;
                        w_state_nxt = S_DONE;
                    end else if (resp_gt) begin
                        if (w_guess_ext == r_lo) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            w_hi_nxt    = w_guess_ext - WP1'(1);
                            w_state_nxt = S_NEXT;
                        end
                    end else begin
                        if (w_guess_ext == r_hi) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            w_lo_nxt    = w_guess_ext + WP1'(1);
                            w_state_nxt = S_NEXT;
                        end
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_lo          <= '0;
            r_hi          <= '0;
            r_guess       <= '0;
            r_found       <= '0;
            r_guess_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lo          <= w_lo_nxt;
            r_hi          <= w_hi_nxt;
            r_guess       <= w_guess_nxt;
            r_found       <= w_found_nxt;
            r_guess_valid <= (w_state_nxt == S_QUERY);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_done        <= (w_state_nxt == S_DONE);
            r_err         <= (w_state_nxt == S_ERR);
        end
    end

    assign guess       = r_guess;
    assign guess_valid = r_guess_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign found       = r_found;
    assign err         = r_err;

`ifdef SAR_ITER_COUNT_EN
    logic [7:0] r_iter;

    // Saturating count of accepted responses since the last accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter <= '0;
        end else if (w_start_acc) begin
            r_iter <= '0;
        end else if (w_accept && (r_iter != 8'hFF)) begin
            r_iter <= r_iter + 8'd1;
        end
    end

    assign iter_count = r_iter;
`endif

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search initiator: the requesting side of a magnitude-compare interface.
- It issues candidate values, consumes the gt/lt/eq result from an external comparator against a hidden target, and binary-searches to the target.
- It sits upstream of a comparator stage, for threshold finding and calibration loops.
- Converges in at most WIDTH+1 queries.

Parameters:
- WIDTH, 4, bit width of the candidate/target value (2..16).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new search. Sampled only in IDLE.
- guess  output  WIDTH  current candidate, registered. Stable while guess_valid=1.
- guess_valid  output  1  candidate presented. Held until the response is accepted.
- resp_valid  input  1  comparator result valid. Accepted when guess_valid & resp_valid.
- resp_gt  input  1  guess > target.
- resp_lt  input  1  guess < target.
- resp_eq  input  1  guess == target.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse: target found.
- found  output  WIDTH  found value. Loaded with done, held until the next accepted start.
- err  output  1  one-cycle pulse: search aborted.

Behaviour:
- Reset (async, rst=1): state=IDLE; guess=0, guess_valid=0, busy=0, done=0, err=0, found=0; internal lo=0, hi=0.
- States: IDLE, NEXT, QUERY, DONE, ERR.
- IDLE:
  - start=1 -> lo=0, hi=2^WIDTH-1, go to NEXT.
  - start is ignored in all other states.
- NEXT:
  - guess <= lo + ((hi-lo)>>1), computed at WIDTH+1 bits, floor.
  - Go to QUERY.
- QUERY:
  - guess_valid=1.
  - Waits indefinitely while resp_valid=0.
  - On accept, the response must be exactly one-hot over {gt, lt, eq}. Zero or more than one flag set -> ERR.
  - eq -> found <= guess, go to DONE.
  - gt -> if guess==lo, go to ERR (range exhausted); else hi <= guess-1, go to NEXT.
  - lt -> if guess==hi, go to ERR; else lo <= guess+1, go to NEXT.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, then IDLE. found is unchanged.
- resp_valid is ignored outside QUERY.
- All lo/hi arithmetic is done at WIDTH+1 bits; no wrap at 0 or 2^WIDTH-1 is possible because of the exhaustion checks.
- Latency:
  - start sampled at edge t -> first guess_valid in cycle t+2.
  - Response accepted at edge k -> guess_valid low in cycle k+1, high again in k+2 with the new guess.
  - eq accepted at edge k -> done high in cycle k+1.
- Reset mid-search aborts immediately to the reset values; no done or err pulse.

Optional Feature:
- Macro: SAR_ITER_COUNT_EN.
- Defined:
  - Adds output iter_count, 8 bits.
  - Cleared on accepted start.
  - Incremented on each accepted response, saturating at 255.
  - Held after DONE/ERR until the next start. Reset value 0.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan (WIDTH=4):
- Target 11, oracle answers correctly -> guesses 7(lt), 11(eq); done pulse, found=11, busy low the cycle after done; iter_count=2.
- Target 0 -> guesses 7, 3, 1 (gt each), then 0(eq); found=0, iter_count=4.
- Target 15 -> guesses 7, 11, 13, 14 (lt each), then 15(eq); found=15, iter_count=5, no err.
- Oracle answers gt to the first guess 7, then gt to 3, 1, 0 -> err pulse after the gt at guess 0; done never asserts; found keeps its previous value.
- Response with gt=1 and eq=1 at first guess -> err pulse next cycle, back to IDLE; a start with resp_valid held low for 10 cycles -> guess=7 and guess_valid held stable all 10 cycles.
- Reset asserted during QUERY of the second guess -> all outputs 0 immediately; start pulsed during busy is ignored; a new start after reset with target 5 -> guesses 7(gt), 3(lt), 5(eq); found=5.
